act_pipe_unit: RTL and testbench

- Pipelined, parametrised successor of the tile activation stage. Sits between the tile accumulator and the output merge path.
- Applies a runtime-selectable element-wise activation to LANES signed fixed-point lanes: bypass, ReLU, leaky ReLU, or clamp.
- Fully registered, 2-stage, valid/ready elastic pipeline. Sustains one vector per cycle under no backpressure.

---
 rtl/act_pipe_unit.sv | 124 ++++++++++++
 tb/tb_act_pipe_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_pipe_unit.sv
// act_pipe_unit: 2-stage elastic activation pipeline over LANES signed lanes.
// Optional ACT_STAT_EN adds clip_cnt_o, a saturating count of modified lanes.
module act_pipe_unit #(
   parameter int LANES      = 4,
   parameter int DW         = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            mode_i,
   input  logic [DW-1:0]         clip_i,
   input  logic [DW*LANES-1:0]   data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DW*LANES-1:0]   data_o,
   output logic                  valid_o,
`ifdef ACT_STAT_EN
   output logic [31:0]           clip_cnt_o,
`endif
   input  logic                  ready_i
);

   localparam int PW = $clog2(LANES + 1);

   logic                v1_q, v1_d;
   logic                v2_q, v2_d;
   logic [DW*LANES-1:0] d1_q, d1_d;
   logic [DW*LANES-1:0] d2_q, d2_d;
   logic [DW*LANES-1:0] act_y;
   logic [PW-1:0]       mod_cnt;
   logic                in_acc;
   logic                adv;

   assign ready_o = !v1_q || !v2_q || ready_i;
   assign valid_o = v2_q;
   assign data_o  = d2_q;
   assign in_acc  = valid_i && ready_o && !rst;
   assign adv     = v1_q && (!v2_q || ready_i);

   always_comb begin
      logic signed [DW-1:0] x;
      logic signed [DW-1:0] y;
      logic signed [DW:0]   xe;
      logic signed [DW:0]   ce;
      logic                 neg;
      logic                 over;
      act_y   = '0;
      mod_cnt = '0;
      ce      = {1'b0, clip_i};
      for (int c = 0; c < LANES; c++) begin
         x    = data_i[c*DW +: DW];
         neg  = x[DW-1];
         xe   = {x[DW-1], x};
         over = xe > ce;
         unique case (mode_i)
            2'd0: y = x;
            2'd1: y = neg ? '0 : x;
            2'd2: y = neg ? (x >>> LEAK_SHIFT) : x;
            2'd3: y = neg ? '0 : (over ? clip_i : x);
            default: y = x;
         endcase
         act_y[c*DW +: DW] = y;
         // a lane counts as modified if it was negative (modes 1-3) or clamped
         if ((mode_i != 2'd0 && neg) || (mode_i == 2'd3 && over))
            mod_cnt = mod_cnt + {{(PW-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      v1_d = v1_q;
      v2_d = v2_q;
      d1_d = d1_q;
      d2_d = d2_q;
      if (adv) begin
         v2_d = 1'b1;
         d2_d = d1_q;
      end else if (v2_q && ready_i) begin
         v2_d = 1'b0;
      end
      if (in_acc) begin
         v1_d = 1'b1;
         d1_d = act_y;
      end else if (adv) begin
         v1_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         d1_q <= d1_d;
         d2_q <= d2_d;
      end
   end

`ifdef ACT_STAT_EN
   logic [31:0] cnt_q, cnt_d;
   logic [32:0] cnt_sum;

   always_comb begin
      cnt_d   = cnt_q;
      cnt_sum = {1'b0, cnt_q} + {{(33-PW){1'b0}}, mod_cnt};
      if (in_acc)
         cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign clip_cnt_o = cnt_q;
`else
   logic [PW-1:0] mod_cnt_unused;
   assign mod_cnt_unused = mod_cnt;
`endif

endmodule

// File: tb/tb_act_pipe_unit.sv
// Bench for act_pipe_unit: directed cases plus random traffic against a
// queue-based model of a 2-deep, 2-cycle-latency elastic pipeline.
module tb_act_pipe_unit;

   logic        clk;
   logic        rst;
   logic [1:0]  mode_i;
   logic [7:0]  clip_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
`ifdef ACT_STAT_EN
   logic [31:0] clip_cnt_o;
`endif

   act_pipe_unit #(.LANES(4), .DW(8), .LEAK_SHIFT(3)) dut (
      .clk(clk), .rst(rst), .mode_i(mode_i), .clip_i(clip_i),
      .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o),
`ifdef ACT_STAT_EN
      .clip_cnt_o(clip_cnt_o),
`endif
      .ready_i(ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      int          t;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          popped = 0;
   bit          started = 0;
   bit          last_ia;
   logic        obs_valid, obs_ready;
   logic [31:0] obs_data;
   longint      mcnt = 0;

   task automatic check(input string n, input logic [63:0] a,
                        input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   function automatic logic [31:0] pack(input int a, input int b,
                                        input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   function automatic int lane_act(input int m, input int clip, input int x);
      if (m == 0) return x;
      if (x < 0) begin
         if (m == 2) return -((-x + 7) / 8);
         return 0;
      end
      if (m == 3 && x > clip) return clip;
      return x;
   endfunction

   function automatic logic [31:0] model_vec(input logic [1:0] m,
                                             input logic [7:0] c,
                                             input logic [31:0] d);
      logic [31:0] r;
      logic [7:0]  b;
      int          x, y;
      for (int i = 0; i < 4; i++) begin
         b = d[i*8 +: 8];
         x = (b >= 8'd128) ? int'(b) - 256 : int'(b);
         y = lane_act(int'(m), int'(c), x);
         r[i*8 +: 8] = y[7:0];
      end
      return r;
   endfunction

   function automatic int model_mods(input logic [1:0] m,
                                     input logic [7:0] c,
                                     input logic [31:0] d);
      int n = 0;
      logic [7:0] b;
      int x;
      for (int i = 0; i < 4; i++) begin
         b = d[i*8 +: 8];
         x = (b >= 8'd128) ? int'(b) - 256 : int'(b);
         if (m != 0 && x < 0) n++;
         else if (m == 3 && x > int'(c)) n++;
      end
      return n;
   endfunction

   task automatic step(input logic v, input logic [1:0] m,
                       input logic [7:0] c, input logic [31:0] d,
                       input logic rdy, input logic r);
      logic        er, ev, ia, oa;
      logic [31:0] ed;
      @(negedge clk);
      valid_i = v; mode_i = m; clip_i = c;
      data_i = d; ready_i = rdy; rst = r;
      #1;
      er = (q.size() < 2) || rdy;
      ev = (q.size() > 0) && (q[0].t <= cyc);
      ed = ev ? q[0].d : 32'h0;
      obs_valid = valid_o; obs_ready = ready_o; obs_data = data_o;
      if (started) begin
         check("ready_o", {63'b0, ready_o}, {63'b0, er});
         check("valid_o", {63'b0, valid_o}, {63'b0, ev});
         if (ev) check("data_o", {32'b0, data_o}, {32'b0, ed});
`ifdef ACT_STAT_EN
         check("clip_cnt_o", {32'b0, clip_cnt_o}, mcnt);
`endif
      end
      ia = v && er && !r;
      oa = ev && rdy;
      last_ia = ia;
      @(posedge clk);
      cyc++;
      if (r) begin
         q.delete();
         mcnt = 0;
         started = 1;
      end else begin
         if (oa) begin
            void'(q.pop_front());
            popped++;
         end
         if (ia) begin
            q.push_back('{d: model_vec(m, c, d), t: cyc + 1});
            mcnt = mcnt + model_mods(m, c, d);
            if (mcnt > 64'hFFFF_FFFF) mcnt = 64'hFFFF_FFFF;
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 2'd0, 8'd0, 32'h0, rdy, 1'b0);
   endtask

   function automatic logic [7:0] rnd_lane();
      case ($urandom_range(0, 5))
         0: return 8'h80;
         1: return 8'h7F;
         2: return 8'h00;
         3: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int i, j, p0;
      logic [31:0] rv;
      rst = 1'b1; valid_i = 0; mode_i = 0; clip_i = 0;
      data_i = 0; ready_i = 0;
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      idle(1);
      check("reset_valid", {63'b0, obs_valid}, 64'd0);
      check("reset_ready", {63'b0, obs_ready}, 64'd1);

      // ReLU literal, latency and single-cycle valid
      step(1, 2'd1, 8'd0, pack(-5, 0, 7, -128), 1, 0);
      idle(1);
      check("relu_latency", {63'b0, obs_valid}, 64'd0);
      idle(1);
      check("relu_valid", {63'b0, obs_valid}, 64'd1);
      check("relu_data", {32'b0, obs_data}, {32'b0, pack(0, 0, 7, 0)});
      idle(1);
      check("relu_one_cycle", {63'b0, obs_valid}, 64'd0);

      // leaky literal
      step(1, 2'd2, 8'd0, pack(-8, -1, -128, 20), 1, 0);
      idle(1);
      idle(1);
      check("leaky_data", {32'b0, obs_data}, {32'b0, pack(-1, -1, -16, 20)});

      // clamp literal, counter from a fresh reset
      step(0, 0, 0, 0, 1, 1);
      step(1, 2'd3, 8'd6, pack(-3, 4, 6, 100), 1, 0);
      idle(1);
      idle(1);
      check("clamp_data", {32'b0, obs_data}, {32'b0, pack(0, 4, 6, 6)});
`ifdef ACT_STAT_EN
      check("clamp_cnt", {32'b0, clip_cnt_o}, 64'd2);
`endif

      // 10 back-to-back vectors, mode toggling, downstream stall
      p0 = popped;
      i = 0;
      for (j = 0; j < 60 && (popped - p0) < 10; j++) begin
         rv = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
         step(i < 10, 2'(i % 2), 8'd0, rv, !(j >= 3 && j <= 6), 0);
         if (j == 5)
            check("b2b_full_ready", {63'b0, obs_ready}, 64'd0);
         if (last_ia) i++;
      end
      check("b2b_count", 64'(popped - p0), 64'd10);

      // reset mid-stream with two vectors in flight
      for (j = 0; j < 4; j++)
         step(1, 2'd1, 0, pack(-1, 2, -3, 4), 1, 0);
      step(1, 2'd1, 0, pack(-1, 2, -3, 4), 1, 1);
      idle(1);
      check("rst_valid", {63'b0, obs_valid}, 64'd0);
      check("rst_ready", {63'b0, obs_ready}, 64'd1);
`ifdef ACT_STAT_EN
      check("rst_cnt", {32'b0, clip_cnt_o}, 64'd0);
`endif
      for (j = 0; j < 4; j++) begin
         idle(1);
         check("rst_no_stale", {63'b0, obs_valid}, 64'd0);
      end

`ifdef ACT_STAT_EN
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      mcnt = 64'hFFFF_FFFE;
      step(1, 2'd1, 0, pack(-1, -2, -3, -4), 1, 0);
      idle(1);
      check("cnt_saturate", {32'b0, clip_cnt_o}, 64'hFFFF_FFFF);
      step(0, 0, 0, 0, 1, 1);
`endif

      // random traffic
      for (j = 0; j < 3000; j++) begin
         rv = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
         step($urandom_range(0, 9) < 7, 2'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20)),
              rv, $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
      end

      for (j = 0; j < 20 && q.size() > 0; j++) idle(1);
      check("drain_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
